// File: rtl/my_register_pkg.sv
// Shared register header: control-code width and encodings understood by my_register.
package my_register_pkg;

  localparam int CTRL_WIDTH = 3;

  typedef enum logic [CTRL_WIDTH-1:0] {
    REG_NOP  = 3'd0,
    REG_CLR  = 3'd1,
    REG_LOAD = 3'd2,
    REG_INCR = 3'd3,
    REG_DECR = 3'd4
  } reg_ctrl_e;

endpackage

// File: rtl/reg_cmd_sequencer_pkg.sv
// Shared sequencer header: command opcodes and FSM state codes for reg_cmd_sequencer.
package reg_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_SET        = 2'd0,
    OP_COUNT_UP   = 2'd1,
    OP_COUNT_DOWN = 2'd2,
    OP_CLEAR      = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  function automatic logic is_count(input cmd_op_e op);
    return (op == OP_COUNT_UP) || (op == OP_COUNT_DOWN);
  endfunction

endpackage

// File: rtl/my_register.sv
// Controlled register paired with reg_cmd_sequencer: hold, clear, load, increment, decrement (wraps).
module my_register
  import my_register_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    case (ctrl)
      REG_CLR:  q_d = '0;
      REG_LOAD: q_d = data;
      REG_INCR: q_d = q_q + 1'b1;
      REG_DECR: q_d = q_q - 1'b1;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/reg_cmd_sequencer.sv
// Command sequencer driving my_register; REG_CMD_SEQUENCER_SAT_EN enables stop-at-limit counting.
module reg_cmd_sequencer
  import my_register_pkg::*;
  import reg_cmd_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CTRL_WIDTH = my_register_pkg::CTRL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_value,
  input  logic [DATA_WIDTH-1:0] cmd_steps,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] reg_q,
  output logic [CTRL_WIDTH-1:0] reg_ctrl,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            status,
  output logic [1:0]            dbg_state
);

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and cmd_op/value/steps are ignored after that edge.

  seq_state_e            state_q;
  cmd_op_e               op_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic [1:0]            status_q;
  logic                  sat_c;
  reg_ctrl_e             ctrl_c;

`ifdef REG_CMD_SEQUENCER_SAT_EN
  always_comb begin
    sat_c = 1'b0;
    if (op_q == OP_COUNT_UP)   sat_c = &reg_q;
    if (op_q == OP_COUNT_DOWN) sat_c = ~|reg_q;
  end
`else
  // Register feedback only matters for saturation; keep it referenced.
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;
  assign sat_c        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SET;
      value_q  <= '0;
      cnt_q    <= '0;
      status_q <= 2'b00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op_e'(cmd_op);
            value_q  <= cmd_value;
            cnt_q    <= cmd_steps;
            status_q <= 2'b00;
            if (!is_count(cmd_op_e'(cmd_op))) state_q <= ST_EXEC;
            else if (cmd_steps == '0)          state_q <= ST_DONE;
            else                               state_q <= ST_STEP;
          end
        end
        ST_EXEC: state_q <= ST_DONE;
        ST_STEP: begin
          cnt_q <= cnt_q - 1'b1;
          if (abort) begin
            status_q <= 2'b01;
            state_q  <= ST_DONE;
          end else if (sat_c) begin
            status_q <= 2'b10;
            state_q  <= ST_DONE;
          end else if (cnt_q == DATA_WIDTH'(1)) begin
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore decode of state, except abort/saturation squash the step in the same cycle.
  always_comb begin
    ctrl_c = REG_NOP;
    case (state_q)
      ST_EXEC: ctrl_c = (op_q == OP_SET) ? REG_LOAD : REG_CLR;
      ST_STEP: begin
        if (!abort && !sat_c)
          ctrl_c = (op_q == OP_COUNT_DOWN) ? REG_DECR : REG_INCR;
      end
      default: ctrl_c = REG_NOP;
    endcase
  end

  assign reg_ctrl  = CTRL_WIDTH'(ctrl_c);
  assign reg_data  = (state_q == ST_EXEC && op_q == OP_SET) ? value_q : '0;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign status    = status_q;
  assign dbg_state = state_q;

endmodule

// File: doc/reg_cmd_sequencer.md
REG_CMD_SEQUENCER -- requirements
Module: reg_cmd_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of register data, value and step count, SHALL be supported for values 2 to 32.
REQ-002 Parameter CTRL_WIDTH, default 3: register control code width, SHALL be taken from the shared header.
REQ-003 clk  in  1: single clock, all state SHALL update on its rising edge.
REQ-004 rst  in  1: asynchronous, active-low reset, SHALL act on its falling edge and while held low.
REQ-005 cmd_valid  in  1: command request.
REQ-006 cmd_ready  out  1: sequencer can accept a command.
REQ-007 cmd_op  in  2: 0 SET, 1 COUNT_UP, 2 COUNT_DOWN, 3 CLEAR.
REQ-008 cmd_value  in  DATA_WIDTH: load value for SET.
REQ-009 cmd_steps  in  DATA_WIDTH: step count for COUNT_UP and COUNT_DOWN.
REQ-010 abort  in  1: terminate an active count.
REQ-011 reg_q  in  DATA_WIDTH: current register contents, fed back from the register output.
REQ-012 reg_ctrl  out  CTRL_WIDTH: register control code; NOP=0, CLR=1, LOAD=2, INCR=3, DECR=4.
REQ-013 reg_data  out  DATA_WIDTH: register load data.
REQ-014 busy  out  1: a command is in progress.
REQ-015 done  out  1: one-cycle completion pulse.
REQ-016 status  out  2: bit0 aborted, bit1 saturated; valid while done=1, held until next accept.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, STEP and DONE; in IDLE, cmd_ready=1 and busy=0; in all other states, cmd_ready=0 and busy=1.
REQ-018 Accept SHALL occur when cmd_valid and cmd_ready are both 1 at a clock edge; op, value and steps SHALL be latched then and ignored afterwards.
REQ-019 reg_ctrl SHALL be a Moore output of state: NOP in IDLE and DONE, the op-specific code in EXEC and STEP.
REQ-020 SET SHALL proceed IDLE->EXEC (reg_ctrl=LOAD, reg_data=latched value)->DONE->IDLE, with done asserted 2 cycles after accept.
REQ-021 CLEAR SHALL proceed IDLE->EXEC (reg_ctrl=CLR)->DONE->IDLE.
REQ-022 COUNT_UP/COUNT_DOWN with steps=k>0 SHALL spend exactly k STEP cycles, each with reg_ctrl=INCR/DECR, then go to DONE, so done asserts k+1 cycles after accept.
REQ-023 A count with steps=0 SHALL go IDLE->DONE directly, with reg_ctrl held at NOP throughout.
REQ-024 The remaining-step counter SHALL be DATA_WIDTH bits wide and decrement once per STEP cycle; steps=2^DATA_WIDTH-1 SHALL be legal.
REQ-025 abort=1 in a STEP cycle SHALL force reg_ctrl=NOP that cycle, go to DONE, and set status=01; abort in any other state SHALL be ignored.
REQ-026 reg_data SHALL equal the latched value in EXEC for SET and 0 otherwise.
REQ-027 Without saturation, counting SHALL wrap modulo 2^DATA_WIDTH in the register (e.g. 8'hFF INCR -> 8'h00).
REQ-028 cmd_valid held across DONE SHALL be accepted in the following IDLE cycle, giving no back-to-back accept without an IDLE cycle.

Reset
REQ-029 Reset SHALL set: state IDLE, cmd_ready=1, busy=0, done=0, status=00, reg_ctrl=NOP, reg_data=0, latched fields=0.
REQ-030 Reset mid-command SHALL abandon the command with no done pulse, and reg_ctrl SHALL be NOP immediately (asynchronously).

Configuration
REQ-031 Macro REG_CMD_SEQUENCER_SAT_EN defined: in a STEP cycle, if reg_q is all-ones (up) or zero (down), the sequencer SHALL drive NOP, go to DONE, and set status=10.
REQ-032 If abort and saturation coincide, abort SHALL win and status SHALL be 01.
REQ-033 Macro undefined: saturation logic SHALL be absent, status bit1 SHALL be constant 0, and wrap per REQ-027 SHALL apply.

Structure
REQ-034 Register control encodings and CTRL_WIDTH SHALL live in the shared register header; cmd_op encodings and FSM state codes SHALL live in a shared sequencer header.
REQ-035 The module SHALL be self-contained with no sub-module; the bench SHALL pair it with my_register, connecting reg_ctrl/reg_data/reg_q.

Verification (DATA_WIDTH=8, my_register attached)
REQ-036 SET value 8'h5A -> LOAD for 1 cycle, done 2 cycles after accept, reg_q=8'h5A, status=00.
REQ-037 reg_q=8'h10, COUNT_UP steps=5 -> 5 INCR cycles, done at accept+6, reg_q=8'h15.
REQ-038 reg_q=8'h02, COUNT_DOWN steps=4 -> with SAT_EN: reg_q=8'h00, status=10, 2 DECR cycles issued; without SAT_EN: reg_q=8'hFE, status=00.
REQ-039 COUNT_UP steps=200, abort at 3rd STEP cycle -> 2 INCR issued, status=01, done next cycle.
REQ-040 COUNT_UP steps=0 -> reg_ctrl never leaves NOP, done at accept+1; rst low during a steps=50 count -> immediate IDLE, no done pulse, reg_q=0.
